// File: rtl/nvdla_csb_responder.sv
// CSB register responder: a small register file behind the NVDLA CSB handshake.
// Holds one outstanding request; reads and non-posted writes answer after
// LATENCY cycles, while posted writes complete silently and back-to-back.
// Ports:
//   clk_i, rst_ni, clear_i               clock, async active-low reset, sync clear
//   csb2nvdla_valid/ready                request handshake
//   csb2nvdla_addr/wdat/write/nposted    request payload (word address)
//   nvdla2csb_valid/data                 one-cycle read response
//   nvdla2csb_wr_complete                one-cycle non-posted write completion
//   err_o                                pulse after an out-of-range access
//   txn_cnt_o                            wrapping count of accepted requests
module nvdla_csb_responder #(
  parameter int unsigned NREGS     = 16,
  parameter int unsigned LATENCY   = 2,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [31:0] ID_VALUE  = 32'h4E56_444C
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        csb2nvdla_valid,
  output logic        csb2nvdla_ready,
  input  logic [15:0] csb2nvdla_addr,
  input  logic [31:0] csb2nvdla_wdat,
  input  logic        csb2nvdla_write,
  input  logic        csb2nvdla_nposted,
  output logic        nvdla2csb_valid,
  output logic [31:0] nvdla2csb_data,
  output logic        nvdla2csb_wr_complete,
  output logic        err_o,
  output logic [15:0] txn_cnt_o
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_rd_q, pend_rd_d;   // pending response is a read
  logic [DW-1:0]   rdata_q, rdata_d;       // read data captured at acceptance
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   data_q, data_d;
  logic            wc_q, wc_d;
  logic            err_q, err_d;
  logic [AW-1:0]   txn_q, txn_d;
  logic [DW-1:0]   regs_q [NREGS];

  logic            accept;
  logic            needs_resp;
  logic [AW-1:0]   idx;
  logic            in_range;
  logic [IW-1:0]   widx;
  logic            reg_we;
  logic [DW-1:0]   rd_mux;

  // Request decode; clear wins over acceptance.
  assign accept     = csb2nvdla_valid && ready_q && !clear_i;
  assign needs_resp = !csb2nvdla_write || csb2nvdla_nposted;
  assign idx        = AW'(csb2nvdla_addr - BASE_ADDR);
  assign in_range   = 32'(idx) < NREGS;
  assign widx       = IW'(idx);
  assign reg_we     = accept && csb2nvdla_write && in_range && (widx != '0);
  assign rd_mux     = !in_range      ? '0 :
                      (widx == '0)   ? ID_VALUE :
                                       regs_q[widx];

  // State register and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_rd_q <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      wc_q      <= 1'b0;
      err_q     <= 1'b0;
      txn_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_rd_q <= pend_rd_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      wc_q      <= wc_d;
      err_q     <= err_d;
      txn_q     <= txn_d;
    end
  end

  // Register array; index 0 is never written (it reads as ID_VALUE).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (clear_i) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[widx] <= csb2nvdla_wdat;
    end
  end

  // Next-state logic. WAIT leaves when the counter reaches its last step so
  // that RESP lands exactly LATENCY cycles after acceptance.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && needs_resp) begin
          pend_rd_d = !csb2nvdla_write;
          if (LATENCY <= 1) begin
            state_d = ST_RESP;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      pend_rd_d = 1'b0;
    end
  end

  // Output logic, computed from the next state so the outputs are registered.
  always_comb begin
    rdata_d = accept ? rd_mux : rdata_q;
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP) && pend_rd_d;
    wc_d    = (state_d == ST_RESP) && !pend_rd_d;
    data_d  = valid_d ? rdata_d : '0;
    err_d   = accept && !in_range;
    txn_d   = accept ? txn_q + AW'(1) : txn_q;
    if (clear_i) begin
      rdata_d = '0;
      txn_d   = '0;
    end
  end

  assign csb2nvdla_ready       = ready_q;
  assign nvdla2csb_valid       = valid_q;
  assign nvdla2csb_data        = data_q;
  assign nvdla2csb_wr_complete = wc_q;
  assign err_o                 = err_q;
  assign txn_cnt_o             = txn_q;

endmodule

// File: tb/tb_nvdla_csb_responder.sv
// Testbench for nvdla_csb_responder: a LATENCY=2 instance checked every cycle
// against an event-schedule model, plus a LATENCY=1 instance for the short
// latency and counter-wrap cases.
module tb_nvdla_csb_responder;

  localparam int unsigned LAT = 2;
  localparam int unsigned NR  = 16;
  localparam logic [31:0] ID  = 32'h4E56_444C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        clr = 1'b0, v = 1'b0, wr = 1'b0, np = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdat = '0;
  logic        rdy, rv, wc, err;
  logic [31:0] rd;
  logic [15:0] txn;

  logic        clr1 = 1'b0, v1 = 1'b0, w1 = 1'b0, np1 = 1'b0;
  logic [15:0] a1 = '0;
  logic [31:0] wd1 = '0;
  logic        rdy1, rv1, wc1, err1;
  logic [31:0] rd1;
  logic [15:0] txn1;

  nvdla_csb_responder #(.NREGS(NR), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr),
    .csb2nvdla_valid(v), .csb2nvdla_ready(rdy), .csb2nvdla_addr(addr),
    .csb2nvdla_wdat(wdat), .csb2nvdla_write(wr), .csb2nvdla_nposted(np),
    .nvdla2csb_valid(rv), .nvdla2csb_data(rd), .nvdla2csb_wr_complete(wc),
    .err_o(err), .txn_cnt_o(txn)
  );

  nvdla_csb_responder #(.NREGS(NR), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr1),
    .csb2nvdla_valid(v1), .csb2nvdla_ready(rdy1), .csb2nvdla_addr(a1),
    .csb2nvdla_wdat(wd1), .csb2nvdla_write(w1), .csb2nvdla_nposted(np1),
    .nvdla2csb_valid(rv1), .nvdla2csb_data(rd1), .nvdla2csb_wr_complete(wc1),
    .err_o(err1), .txn_cnt_o(txn1)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: register contents plus the scheduled edge of each pending event.
  logic [31:0] m_regs [NR];
  logic [15:0] m_txn;
  bit          m_ready;
  int          ed = 0;
  int          free_edge = 0;
  bit          pend;
  int          pend_edge;
  bit          pend_rd;
  logic [31:0] pend_data;
  int          err_edge = -1;

  bit          last_acc, got_rv, got_wc, got_err;
  logic [31:0] last_data;

  task automatic m_clear();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_txn     = '0;
    pend      = 1'b0;
    err_edge  = -1;
    free_edge = ed;
  endtask

  // One clock edge: predict, advance, then compare every output.
  task automatic step();
    bit          acc, inr;
    logic [15:0] idx;
    bit          ev, ew;
    acc = v && m_ready && !clr;
    idx = addr;
    inr = idx < 16'(NR);
    @(posedge clk);
    ed++;
    if (clr) begin
      m_clear();
    end else if (acc) begin
      m_txn++;
      if (!inr) err_edge = ed;
      if (!wr || np) begin
        pend      = 1'b1;
        pend_edge = ed + LAT - 1;
        pend_rd   = !wr;
        pend_data = (!wr && inr) ? ((idx == 16'd0) ? ID : m_regs[idx[3:0]]) : 32'h0;
        free_edge = ed + LAT;
      end
      if (wr && inr && idx != 16'd0) m_regs[idx[3:0]] = wdat;
    end
    last_acc = acc;
    m_ready  = (ed >= free_edge);
    #1;
    ev = pend && (pend_edge == ed) && pend_rd;
    ew = pend && (pend_edge == ed) && !pend_rd;
    chk("ready", 32'(rdy), 32'(m_ready));
    chk("valid", 32'(rv), 32'(ev));
    chk("data", rd, ev ? pend_data : 32'h0);
    chk("wr_complete", 32'(wc), 32'(ew));
    chk("err", 32'(err), 32'(err_edge == ed));
    chk("txn", 32'(txn), 32'(m_txn));
    if (rv) begin got_rv = 1'b1; last_data = rd; end
    if (wc) got_wc = 1'b1;
    if (err) got_err = 1'b1;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    m_clear();
    m_ready = 1'b0;
    #1;
    chk("rst ready", 32'(rdy), 32'h0);
    chk("rst valid", 32'(rv), 32'h0);
    chk("rst data", rd, 32'h0);
    chk("rst wr_complete", 32'(wc), 32'h0);
    chk("rst err", 32'(err), 32'h0);
    chk("rst txn", 32'(txn), 32'h0);
    repeat (2) @(posedge clk);
    #1 chk("rst ready held", 32'(rdy), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  // Issue one request, wait for acceptance (bounded), then drain the response.
  task automatic do_txn(input bit w, input bit n, input logic [15:0] a, input logic [31:0] d);
    bit done;
    v = 1'b1; wr = w; np = n; addr = a; wdat = d;
    got_rv = 1'b0; got_wc = 1'b0; got_err = 1'b0; last_data = '0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      done = last_acc;
    end
    chk("accept", 32'(done), 32'h1);
    v = 1'b0;
    repeat (LAT + 1) step();
  endtask

  typedef struct {
    bit          w;
    bit          n;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  localparam int NT = 11;
  vec_t tbl [NT];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          low;
    logic [15:0] t0;

    tbl[0]  = '{1'b1, 1'b1, 16'd3,     32'hA5A5_0001, 32'h0,          1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'd3,     32'h0,         32'hA5A5_0001, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 16'd0,     32'h0,         ID,            1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'd0,     32'hDEAD_BEEF, 32'h0,          1'b0};
    tbl[4]  = '{1'b0, 1'b0, 16'd0,     32'h0,         ID,            1'b0};
    tbl[5]  = '{1'b0, 1'b0, 16'd16,    32'h0,         32'h0,          1'b1};
    tbl[6]  = '{1'b1, 1'b1, 16'd20,    32'h1234_5678, 32'h0,          1'b1};
    tbl[7]  = '{1'b0, 1'b0, 16'd15,    32'h0,         32'h0,          1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'hFFFF,  32'h0,         32'h0,          1'b1};
    tbl[9]  = '{1'b1, 1'b1, 16'd15,    32'hCAFE_F00D, 32'h0,          1'b0};
    tbl[10] = '{1'b0, 1'b0, 16'd15,    32'h0,         32'hCAFE_F00D, 1'b0};

    do_reset();

    // Directed single transactions.
    for (int i = 0; i < NT; i++) begin
      do_txn(tbl[i].w, tbl[i].n, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d valid", i), 32'(got_rv), 32'(!tbl[i].w));
      chk($sformatf("tbl%0d wr_complete", i), 32'(got_wc), 32'(tbl[i].w && tbl[i].n));
      chk($sformatf("tbl%0d err", i), 32'(got_err), 32'(tbl[i].exp_err));
      if (!tbl[i].w) chk($sformatf("tbl%0d data", i), last_data, tbl[i].exp_data);
      if (i == 1) chk("txn after np-write+read", 32'(txn), 32'd2);
    end

    // Synchronous clear, then a back-to-back posted burst.
    clr = 1'b1; step(); clr = 1'b0;
    chk("clear txn", 32'(txn), 32'h0);
    v = 1'b1; wr = 1'b1; np = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      addr = 16'(i);
      wdat = 32'h1111_0000 + 32'(i);
      step();
    end
    v = 1'b0; wr = 1'b0;
    chk("burst txn", 32'(txn), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      do_txn(1'b0, 1'b0, 16'(i), 32'h0);
      chk($sformatf("burst readback %0d", i), last_data, 32'h1111_0000 + 32'(i));
    end

    // Backpressure: second request held while the first is pending.
    v = 1'b1; wr = 1'b0; np = 1'b0; addr = 16'd1;
    step();
    t0 = txn;
    addr = 16'd2;
    low = rdy ? 0 : 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (rdy) break;
      low++;
    end
    chk("bp ready-low cycles", 32'(low), 32'(LAT));
    step();
    chk("bp second accept", 32'(txn), 32'(t0 + 16'd1));
    v = 1'b0;
    repeat (LAT + 1) step();

    // Reset while a read is waiting.
    v = 1'b1; wr = 1'b0; addr = 16'd1;
    step();
    v = 1'b0;
    got_rv = 1'b0; got_wc = 1'b0;
    do_reset();
    repeat (LAT + 3) step();
    chk("no valid after reset", 32'(got_rv), 32'h0);
    chk("no wr_complete after reset", 32'(got_wc), 32'h0);
    chk("txn after reset", 32'(txn), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      do_txn(1'b0, 1'b0, 16'(i), 32'h0);
      chk($sformatf("reset readback %0d", i), last_data, 32'h0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      v    = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      np   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 19));
      wdat = $urandom;
      clr  = ($urandom_range(0, 39) == 0);
      step();
    end
    clr = 1'b0; v = 1'b0;
    repeat (LAT + 1) step();

    // LATENCY=1 instance: one-cycle response and counter wrap.
    v1 = 1'b1; w1 = 1'b0; a1 = 16'd0;
    @(posedge clk); #1;
    chk("lat1 valid", 32'(rv1), 32'h1);
    chk("lat1 data", rd1, ID);
    chk("lat1 ready busy", 32'(rdy1), 32'h0);
    v1 = 1'b0;
    @(posedge clk); #1;
    chk("lat1 ready back", 32'(rdy1), 32'h1);
    chk("lat1 valid low", 32'(rv1), 32'h0);
    chk("lat1 data low", rd1, 32'h0);
    chk("lat1 txn", 32'(txn1), 32'h1);
    v1 = 1'b1; w1 = 1'b1; np1 = 1'b1; a1 = 16'd2; wd1 = 32'h0BAD_F00D;
    @(posedge clk); #1;
    chk("lat1 wr_complete", 32'(wc1), 32'h1);
    chk("lat1 wc valid low", 32'(rv1), 32'h0);
    v1 = 1'b0; np1 = 1'b0;
    @(posedge clk); #1;
    v1 = 1'b1; a1 = 16'd1;
    repeat (65533) @(posedge clk);
    #1 chk("lat1 txn at max", 32'(txn1), 32'h0000_FFFF);
    @(posedge clk);
    #1 chk("lat1 txn wrap", 32'(txn1), 32'h0);
    v1 = 1'b0; w1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
